// File: rtl/pcpi_pkg.sv
// Shared types and defaults for the PCPI initiator slice.
package pcpi_pkg;

  localparam int unsigned DEFAULT_PCPI_TIMEOUT = 16;
  localparam int unsigned PCPI_XLEN            = 32;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } pcpi_state_e;

  // Response held for the core: write-enable, trap flag, result word.
  typedef struct packed {
    logic                 wr;
    logic                 trap;
    logic [PCPI_XLEN-1:0] rd;
  } pcpi_rsp_t;

endpackage

// File: rtl/pcpi_timeout_ctr.sv
// Counts idle request cycles; expired flags the last allowed idle cycle.
module pcpi_timeout_ctr
  import pcpi_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_PCPI_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned   CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  // Clear has priority; otherwise advance once per enabled cycle.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/pcpi_initiator.sv
// Core-side PCPI issuer: captures a command, drives the coprocessor request,
// and returns either the responder result or a trap over a valid/ready channel.
module pcpi_initiator
  import pcpi_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_PCPI_TIMEOUT,
  parameter int unsigned XLEN           = PCPI_XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [31:0]     cmd_insn,
  input  logic [XLEN-1:0] cmd_rs1,
  input  logic [XLEN-1:0] cmd_rs2,
  input  logic            abort,
  output logic            pcpi_valid,
  output logic [31:0]     pcpi_insn,
  output logic [XLEN-1:0] pcpi_rs1,
  output logic [XLEN-1:0] pcpi_rs2,
  input  logic            pcpi_busy,
  input  logic            pcpi_ready,
  input  logic            pcpi_wr,
  input  logic [XLEN-1:0] pcpi_rd,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_wr,
  output logic [XLEN-1:0] rsp_rd,
  output logic            rsp_trap
);

  pcpi_state_e state;
  pcpi_rsp_t   rsp_q;
  logic        expired;
  logic        ctr_clr;
  logic        ctr_en;

  // The counter only runs on REQ cycles where the responder is silent; any
  // claim, answer, abort or exit from REQ returns it to zero.
  assign ctr_en  = (state == REQ);
  assign ctr_clr = (state != REQ) || pcpi_busy || pcpi_ready || abort || expired;

  pcpi_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clr    (ctr_clr),
    .en     (ctr_en),
    .expired(expired)
  );

  // Request/response FSM with registered handshake outputs and capture registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cmd_ready  <= 1'b1;
      pcpi_valid <= 1'b0;
      rsp_valid  <= 1'b0;
      pcpi_insn  <= '0;
      pcpi_rs1   <= '0;
      pcpi_rs2   <= '0;
      rsp_q      <= '0;
    end else if (abort) begin
      state      <= IDLE;
      cmd_ready  <= 1'b1;
      pcpi_valid <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            pcpi_insn  <= cmd_insn;
            pcpi_rs1   <= cmd_rs1;
            pcpi_rs2   <= cmd_rs2;
            cmd_ready  <= 1'b0;
            pcpi_valid <= 1'b1;
            state      <= REQ;
          end
        end
        REQ: begin
          if (pcpi_ready) begin
            rsp_q.wr   <= pcpi_wr;
            rsp_q.trap <= 1'b0;
            rsp_q.rd   <= PCPI_XLEN'(pcpi_rd);
            pcpi_valid <= 1'b0;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end else if (!pcpi_busy && expired) begin
            rsp_q.wr   <= 1'b0;
            rsp_q.trap <= 1'b1;
            rsp_q.rd   <= '0;
            pcpi_valid <= 1'b0;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          cmd_ready  <= 1'b1;
          pcpi_valid <= 1'b0;
          rsp_valid  <= 1'b0;
        end
      endcase
    end
  end

  assign rsp_wr   = rsp_q.wr;
  assign rsp_trap = rsp_q.trap;
  assign rsp_rd   = XLEN'(rsp_q.rd);

endmodule
